// File: rtl/phase_pkg.sv
// Shared phase-format constants and types for the receive chain.
// Phases are signed Q8.10 radians; the diff type carries one guard bit.
package phase_pkg;

  localparam int WIDTH    = 19;
  localparam int FRAC     = 10;
  localparam int PI_Q     = 3217;
  localparam int TWO_PI_Q = 6434;

  typedef logic signed [WIDTH-1:0] phase_t;
  typedef logic signed [WIDTH:0]   phase_diff_t;

  // Wrap limits pre-sized to the guarded width so comparisons stay width-matched.
  localparam phase_diff_t PI_X     = phase_diff_t'(PI_Q);
  localparam phase_diff_t NEG_PI_X = phase_diff_t'(-PI_Q);
  localparam phase_diff_t TWO_PI_X = phase_diff_t'(TWO_PI_Q);

endpackage

// File: rtl/phase_diff_if.sv
// Sample/phase bus between the phase extractors and the phase-difference unit.
// The master drives the two phases and the sample strobe; the slave returns out.
interface phase_diff_if;
  import phase_pkg::*;

  logic   sample;
  phase_t A;
  phase_t B;
  phase_t out;

  modport master (output sample, output A, output B, input  out);
  modport slave  (input  sample, input  A, input  B, output out);

endinterface

// File: rtl/phase_wrap.sv
// Single-step wrap of a guarded phase difference into [-pi, pi).
// Inputs outside the legal range get one correction and are then truncated.
module phase_wrap
  import phase_pkg::*;
(
  input  phase_diff_t d,
  output phase_t      w
);

  phase_diff_t wide;

  // NOTE: assign a default before any branch so always_comb never infers a latch.
  always_comb begin
    wide = d;
    if (d >= PI_X) begin
      wide = d - TWO_PI_X;
    end else if (d < NEG_PI_X) begin
      wide = d + TWO_PI_X;
    end
  end

  assign w = wide[WIDTH-1:0];

endmodule

// File: rtl/phase_diff.sv
// Registered phase difference A - B, wrapped into [-pi, pi), one-clock latency.
// The output register loads only on sample and clears asynchronously on reset.
module phase_diff
  import phase_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  phase_diff_if.slave  bus
);

  phase_diff_t diff;
  phase_t      wrapped;

  // Sign-extend both operands so the subtraction can never overflow.
  assign diff = phase_diff_t'({bus.A[WIDTH-1], bus.A}) - phase_diff_t'({bus.B[WIDTH-1], bus.B});

  phase_wrap u_wrap (
    .d (diff),
    .w (wrapped)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out <= '0;
    end else if (bus.sample) begin
      bus.out <= wrapped;
    end
  end

endmodule

// File: tb/tb_phase_diff.sv
// Self-checking bench for phase_diff: vector table, reset/hold sequences
// and a randomized stream compared against an integer wrap model.
module tb_phase_diff;
  import phase_pkg::*;

  logic clock;
  logic reset;
  phase_diff_if bus ();

  int checks;
  int failures;

  phase_diff dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string name;
    int    a;
    int    b;
    int    exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: out=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: wrap A-B by adding/subtracting 2*pi once, then keep the low 19 bits.
  function automatic int ref_wrap(input int a, input int b);
    int d;
    int m;
    d = a - b;
    if (d >= 3217)       d = d - 6434;
    else if (d < -3217)  d = d + 6434;
    m = ((d % 524288) + 524288) % 524288;
    if (m >= 262144) m = m - 524288;
    return m;
  endfunction

  function automatic int out_int();
    return int'(bus.out);
  endfunction

  task automatic drive(input int a, input int b, input logic smp);
    bus.A      = phase_t'(a);
    bus.B      = phase_t'(b);
    bus.sample = smp;
  endtask

  task automatic step(input int a, input int b, input logic smp);
    @(negedge clock);
    drive(a, b, smp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(0, 0, 1'b0);

    vecs.push_back('{"no_wrap_pos",   1024,    512,   512});
    vecs.push_back('{"no_wrap_neg",   -800,    900, -1700});
    vecs.push_back('{"pos_wrap_6000", 3000,  -3000,  -434});
    vecs.push_back('{"d_eq_pi",       3217,      0, -3217});
    vecs.push_back('{"neg_wrap_6000", -3000,  3000,   434});
    vecs.push_back('{"d_eq_neg2pi",   -3217,  3217,     0});
    vecs.push_back('{"b_eq_pi",       0,      3217, -3217});
    vecs.push_back('{"d_eq_2pi",      3217,  -3217,     0});
    vecs.push_back('{"d_eq_negpi",    -3217,     0, -3217});
    vecs.push_back('{"just_below_pi", 3216,      0,  3216});
    vecs.push_back('{"zero",          0,         0,     0});
    vecs.push_back('{"minus_one",     -1,        0,    -1});
    vecs.push_back('{"illegal_neg",   -262144, 262143, 6435});
    vecs.push_back('{"illegal_pos",   262143, -262144, -6435});

    #1;
    check("reset_initial", out_int(), 0);
    @(negedge clock);
    drive(1024, 512, 1'b1);
    @(posedge clock);
    #1;
    check("reset_held_with_sample", out_int(), 0);

    // Leave reset and load a nonzero value, then reset asynchronously mid-cycle.
    @(negedge clock);
    reset = 1'b0;
    step(1024, 512, 1'b1);
    check("load_before_async_reset", out_int(), 512);
    #1 reset = 1'b1;
    #1;
    check("async_reset_no_edge", out_int(), 0);
    step(3000, 1000, 1'b1);
    check("reset_wins_over_sample", out_int(), 0);
    @(negedge clock);
    reset = 1'b0;
    drive(1024, -1024, 1'b1);
    @(posedge clock);
    #1;
    check("first_load_after_reset", out_int(), 2048);

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, 1'b1);
      check(vecs[i].name, out_int(), vecs[i].exp);
    end

    // Hold: sample low freezes out across several edges with changing inputs.
    step(1024, 512, 1'b1);
    check("hold_preload", out_int(), 512);
    for (int i = 0; i < 5; i++) begin
      step(100 * i - 2000, 3000 - 77 * i, 1'b0);
      check("hold", out_int(), 512);
    end
    step(-800, 900, 1'b1);
    check("hold_release", out_int(), -1700);

    // Streaming: every edge loads the wrap of the inputs presented before it.
    for (int i = 0; i < 8000; i++) begin
      int a;
      int b;
      a = int'($urandom_range(6434, 0)) - 3217;
      b = int'($urandom_range(6434, 0)) - 3217;
      step(a, b, 1'b1);
      check("stream", out_int(), ref_wrap(a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
